// File: rtl/input_vector_pkg.sv
// Shared types and helpers for the operand vector buffer:
// FSM state encoding, lane slicing and length clamping.
package input_vector_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Bit offset of channel c inside a packed element tuple.
  function automatic int unsigned lane_lo(
    input int unsigned c,
    input int unsigned w
  );
    return c * w;
  endfunction

  // Requested stream length limited to the storage depth.
  function automatic int unsigned clamp_len(
    input int unsigned req,
    input int unsigned max
  );
    return (req > max) ? max : req;
  endfunction

endpackage

// File: rtl/input_vector_bank.sv
// One bank of operand storage: NUM_CH x MAX_LEN x DATA_WIDTH registers.
// Ports: clk; we/waddr/wdata write port (all channels); raddr/rdata async read.
module input_vector_bank
  import input_vector_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 2,
  parameter int MAX_LEN    = 16,
  parameter int ADDR_WIDTH = $clog2(MAX_LEN)
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [ADDR_WIDTH-1:0]        waddr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0]        raddr,
  output logic [NUM_CH*DATA_WIDTH-1:0] rdata
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH = LW'(MAX_LEN);

  logic [DATA_WIDTH-1:0] mem [NUM_CH][MAX_LEN];
  logic                  in_range;

  // Out-of-range addresses only exist when MAX_LEN is not a power of two.
  assign in_range = {1'b0, waddr} < DEPTH;

  always_ff @(posedge clk) begin
    if (we && in_range) begin
      for (int c = 0; c < NUM_CH; c++) begin
        mem[c][waddr] <=
          wdata[lane_lo(c, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      rdata[lane_lo(c, DATA_WIDTH) +: DATA_WIDTH] =
        mem[c][raddr];
    end
  end

endmodule

// File: rtl/input_vector_buffer.sv
// Operand vector buffer: stores NUM_CH vectors and streams vec_len
// lock-step element tuples over valid/ready after a start pulse.
// Ports: clk, rst (sync, active-high); wr_en/wr_addr/wr_data write;
// vec_len/start/busy/done control; out_valid/out_ready/out_data/
// out_idx/out_last stream.
// Macro INPUT_VECTOR_BUFFER_PINGPONG_EN: two banks, writes go to
// wr_bank (even while busy), each accepted start streams that bank
// and flips wr_bank so the next vector loads alongside the stream.
module input_vector_buffer
  import input_vector_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 2,
  parameter int MAX_LEN    = 16,
  parameter int ADDR_WIDTH = $clog2(MAX_LEN)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH:0]          vec_len,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0]        out_idx,
  output logic                         out_last
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam int TW = NUM_CH * DATA_WIDTH;

  state_t                state;
  state_t                state_n;
  logic [ADDR_WIDTH:0]   len;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH:0]   len_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [TW-1:0]         rd_data;
  logic                  start_ok;
  logic                  hs;
  logic                  at_last;

  assign len_req  = LW'(clamp_len(32'(vec_len), MAX_LEN));
  assign start_ok = (state == IDLE) && start;
  assign hs       = out_valid && out_ready;
  assign at_last  = {1'b0, out_idx} == (len - LW'(1));
  assign out_last = out_valid && at_last;
  assign busy     = (state != IDLE);

  // Element 0 is fetched while idle; afterwards the read pointer
  // runs one element ahead of the presented beat.
  assign rd_addr  = (state == IDLE) ? '0
                                    : rd_ptr[ADDR_WIDTH-1:0];

`ifdef INPUT_VECTOR_BUFFER_PINGPONG_EN
  logic          wr_bank;
  logic          rd_bank;
  logic          rd_sel;
  logic [TW-1:0] rd_data0;
  logic [TW-1:0] rd_data1;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else if (start_ok) begin
      rd_bank <= wr_bank;
      wr_bank <= ~wr_bank;
    end
  end

  assign rd_sel  = (state == IDLE) ? wr_bank : rd_bank;
  assign rd_data = rd_sel ? rd_data1 : rd_data0;

  input_vector_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_CH     (NUM_CH),
    .MAX_LEN    (MAX_LEN),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bank0 (
    .clk   (clk),
    .we    (wr_en && !wr_bank),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data0)
  );

  input_vector_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_CH     (NUM_CH),
    .MAX_LEN    (MAX_LEN),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bank1 (
    .clk   (clk),
    .we    (wr_en && wr_bank),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data1)
  );
`else
  // Writes are blocked while busy so the streamed snapshot is stable;
  // a write alongside an accepted start still lands (state is IDLE).
  input_vector_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_CH     (NUM_CH),
    .MAX_LEN    (MAX_LEN),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bank (
    .clk   (clk),
    .we    (wr_en && !busy),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = (len_req == '0) ? DONE : STREAM;
        end
      end
      STREAM: begin
        if (hs && at_last) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len       <= '0;
      rd_ptr    <= '0;
      out_idx   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= (state_n == DONE);
      unique case (state)
        IDLE: begin
          if (start_ok) begin
            len <= len_req;
            if (len_req != '0) begin
              out_data  <= rd_data;
              out_idx   <= '0;
              out_valid <= 1'b1;
              rd_ptr    <= LW'(1);
            end
          end
        end
        STREAM: begin
          if (hs) begin
            if (at_last) begin
              out_valid <= 1'b0;
            end else begin
              out_data <= rd_data;
              out_idx  <= out_idx + ADDR_WIDTH'(1);
              rd_ptr   <= rd_ptr + LW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_input_vector_buffer.sv
// Scoreboard bench for input_vector_buffer (default parameters).
// Covers default and INPUT_VECTOR_BUFFER_PINGPONG_EN builds.
module tb_input_vector_buffer;

  localparam int DW = 8;
  localparam int NC = 2;
  localparam int ML = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic [AW:0]   vec_len;
  logic          start;
  logic          busy;
  logic          done;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_data;
  logic [AW-1:0] out_idx;
  logic          out_last;

  input_vector_buffer #(
    .DATA_WIDTH (DW),
    .NUM_CH     (NC),
    .MAX_LEN    (ML),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .vec_len   (vec_len),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [15:0] data;
    logic        last;
  } beat_t;

  beat_t      q[$];
  logic [7:0] mdl_a [2][16];
  logic [7:0] mdl_b [2][16];
  int         wb = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         done_cnt = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_wr(input int addr,
                                   input logic [7:0] a,
                                   input logic [7:0] b,
                                   input bit in_busy);
`ifdef INPUT_VECTOR_BUFFER_PINGPONG_EN
    mdl_a[wb][addr] = a;
    mdl_b[wb][addr] = b;
    if (in_busy) begin end
`else
    if (!in_busy) begin
      mdl_a[0][addr] = a;
      mdl_b[0][addr] = b;
    end
`endif
  endfunction

  // Output monitor: every valid beat must match the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", 32'(out_valid), 32'd0);
        end else begin
          chk("out_data", 32'(out_data), 32'(q[0].data));
          chk("out_idx", 32'(out_idx), 32'(q[0].idx));
          chk("out_last", 32'(out_last), 32'(q[0].last));
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  task automatic wr(input int addr,
                    input logic [7:0] a,
                    input logic [7:0] b);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = {b, a};
    @(posedge clk) #1;
    wr_en = 1'b0;
    model_wr(addr, a, b, 1'b0);
  endtask

  // mode 0: ready high; 1: ready 1,0,0,...; 2: stall, busy write and
  // busy start. wa >= 0 writes alongside the start.
  task automatic run(input int len, input int mode, input int wa,
                     input logic [7:0] wa_a, input logic [7:0] wa_b);
    int n;
    int d0;
    int k;
    n  = (len > ML) ? ML : len;
    d0 = done_cnt;
    for (int i = 0; i < n; i++) begin
      q.push_back('{idx: i,
                    data: {mdl_b[wb][i], mdl_a[wb][i]},
                    last: (i == n - 1)});
    end
    vec_len = (AW+1)'(len);
    start   = 1'b1;
    if (wa >= 0) begin
      wr_en   = 1'b1;
      wr_addr = AW'(wa);
      wr_data = {wa_b, wa_a};
    end
    @(posedge clk) #1;
    start = 1'b0;
    wr_en = 1'b0;
    if (wa >= 0) model_wr(wa, wa_a, wa_b, 1'b0);
`ifdef INPUT_VECTOR_BUFFER_PINGPONG_EN
    wb ^= 1;
`endif
    chk("busy_after_start", 32'(busy), 32'd1);
    k = 0;
    while (done_cnt == d0 && k < 300) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (k % 3 == 0);
        default: out_ready = (k >= 3);
      endcase
      if (mode == 2 && k == 1) begin
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_data = 16'h6655;
        start   = 1'b1;
        vec_len = 5'd3;
        model_wr(0, 8'h55, 8'h66, 1'b1);
      end
      if (mode == 2 && k == 2) begin
        wr_en = 1'b0;
        start = 1'b0;
      end
      @(posedge clk) #1;
      k++;
    end
    repeat (3) @(posedge clk) #1;
    chk("done_once", 32'(done_cnt - d0), 32'd1);
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("idle_after", 32'(busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int d0;
    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    vec_len   = '0;
    start     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_idx", 32'(out_idx), 32'd0);
    rst = 1'b0;

    // full-length vector, then clamped length
    for (int i = 0; i < ML; i++) wr(i, 8'(i), 8'(8'hFF - i));
    run(ML, 0, -1, 8'h0, 8'h0);
    for (int i = 0; i < ML; i++) wr(i, 8'(8'h10 + i), 8'(8'h20 + i));
    run(20, 0, -1, 8'h0, 8'h0);

    // basic, then backpressure
    for (int i = 0; i < 4; i++) wr(i, 8'(1 + i), 8'(5 + i));
    run(4, 0, -1, 8'h0, 8'h0);
    run(4, 1, -1, 8'h0, 8'h0);

    // zero length
    run(0, 0, -1, 8'h0, 8'h0);

    // overwrite
    wr(0, 8'hAA, 8'hBB);
    wr(0, 8'hEE, 8'hFF);
    run(2, 0, -1, 8'h0, 8'h0);

    // write and start while busy, then observe their effect
    run(4, 2, -1, 8'h0, 8'h0);
    run(4, 0, -1, 8'h0, 8'h0);

    // write in the same cycle as start
    run(3, 0, 0, 8'h77, 8'h88);
    run(3, 0, -1, 8'h0, 8'h0);

    // reset mid-stream
    for (int i = 0; i < 4; i++) wr(i, 8'(1 + i), 8'(5 + i));
    for (int i = 0; i < 4; i++) begin
      q.push_back('{idx: i,
                    data: {mdl_b[wb][i], mdl_a[wb][i]},
                    last: (i == 3)});
    end
    d0        = done_cnt;
    out_ready = 1'b1;
    vec_len   = 5'd4;
    start     = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    @(posedge clk) #1;
    @(posedge clk) #1;
    rst = 1'b1;
    @(posedge clk) #1;
    rst = 1'b0;
    q.delete();
    wb = 0;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (3) @(posedge clk) #1;
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    run(4, 0, -1, 8'h0, 8'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
